// File: rtl/conv_transpose2d.sv
// rtl/conv_transpose2d.sv - sequential gather-form transposed 2-D convolution over external memories.
// Optional ReLU on the written result when CONVT_RELU_EN is defined.
module conv_transpose2d #(
  parameter int BATCH_SIZE     = 1,
  parameter int IN_CHANNELS    = 1,
  parameter int OUT_CHANNELS   = 2,
  parameter int IN_HEIGHT      = 2,
  parameter int IN_WIDTH       = 2,
  parameter int KERNEL_SIZE    = 2,
  parameter int STRIDE         = 2,
  parameter int PADDING        = 0,
  parameter int OUTPUT_PADDING = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] input_addr,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  input_en,
  output logic [ADDR_WIDTH-1:0] output_addr,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_we,
  output logic                  output_en
);

  localparam int OUT_H     = (IN_HEIGHT - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE + OUTPUT_PADDING;
  localparam int OUT_W     = (IN_WIDTH - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE + OUTPUT_PADDING;
  localparam int ACC_W     = DATA_WIDTH + 8;
  localparam int IN_PLANE  = IN_HEIGHT * IN_WIDTH;
  localparam int IN_BATCH  = IN_CHANNELS * IN_PLANE;
  localparam int OUT_PLANE = OUT_H * OUT_W;
  localparam int OUT_BATCH = OUT_CHANNELS * OUT_PLANE;

  // Every weight is 1 and every bias is 0, so no weight/bias storage is needed.
  localparam logic signed [ACC_W-1:0] WEIGHT = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] BIAS   = '0;

  typedef enum logic [2:0] {IDLE, INIT, TAP, RDW, MAC, STORE, WRITE, DONE_ST} state_t;
  state_t state;

  logic [31:0] b, oc, oy, ox, ic, ky, kx;
  logic [31:0] b_n, oc_n, oy_n, ox_n, ic_n, ky_n, kx_n;
  logic signed [ACC_W-1:0] acc, data_x, prod;
  logic signed [31:0] ny, nx, iy, ix;
  logic tap_ok, last_tap, last_pixel;
  logic [ADDR_WIDTH-1:0] in_addr_c, out_addr_c;
  logic [DATA_WIDTH-1:0] result;

  assign valid = done;

  always_comb begin
    ny = $signed(oy) + PADDING - $signed(ky);
    nx = $signed(ox) + PADDING - $signed(kx);
    iy = ny / STRIDE;
    ix = nx / STRIDE;
    tap_ok = !ny[31] && !nx[31] && (ny % STRIDE == 0) && (nx % STRIDE == 0) &&
             (iy < IN_HEIGHT) && (ix < IN_WIDTH);
    in_addr_c  = ADDR_WIDTH'(b * IN_BATCH + ic * IN_PLANE + $unsigned(iy) * IN_WIDTH + $unsigned(ix));
    out_addr_c = ADDR_WIDTH'(b * OUT_BATCH + oc * OUT_PLANE + oy * OUT_W + ox);
    data_x = ACC_W'($signed(input_data));
    prod   = data_x * WEIGHT;
`ifdef CONVT_RELU_EN
    result = acc[ACC_W-1] ? '0 : acc[DATA_WIDTH-1:0];
`else
    result = acc[DATA_WIDTH-1:0];
`endif
  end

  // Tap order: kx innermost, then ky, then ic.
  always_comb begin
    kx_n = kx + 1;
    ky_n = ky;
    ic_n = ic;
    if (kx == KERNEL_SIZE - 1) begin
      kx_n = '0;
      ky_n = ky + 1;
      if (ky == KERNEL_SIZE - 1) begin
        ky_n = '0;
        ic_n = ic + 1;
      end
    end
    last_tap = (ic == IN_CHANNELS - 1) && (ky == KERNEL_SIZE - 1) && (kx == KERNEL_SIZE - 1);
  end

  // Pixel order: ox innermost, then oy, oc, batch.
  always_comb begin
    ox_n = ox + 1;
    oy_n = oy;
    oc_n = oc;
    b_n  = b;
    if (ox == OUT_W - 1) begin
      ox_n = '0;
      oy_n = oy + 1;
      if (oy == OUT_H - 1) begin
        oy_n = '0;
        oc_n = oc + 1;
        if (oc == OUT_CHANNELS - 1) begin
          oc_n = '0;
          b_n  = b + 1;
        end
      end
    end
    last_pixel = (b == BATCH_SIZE - 1) && (oc == OUT_CHANNELS - 1) &&
                 (oy == OUT_H - 1) && (ox == OUT_W - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      input_en    <= 1'b0;
      output_we   <= 1'b0;
      output_en   <= 1'b0;
      input_addr  <= '0;
      output_addr <= '0;
      output_data <= '0;
      acc         <= '0;
      b  <= '0; oc <= '0; oy <= '0; ox <= '0;
      ic <= '0; ky <= '0; kx <= '0;
    end else begin
      case (state)
        IDLE: begin
          done        <= 1'b0;
          input_en    <= 1'b0;
          output_we   <= 1'b0;
          output_en   <= 1'b0;
          input_addr  <= '0;
          output_addr <= '0;
          output_data <= '0;
          if (start) begin
            b  <= '0; oc <= '0; oy <= '0; ox <= '0;
            state <= INIT;
          end
        end
        INIT: begin
          acc <= BIAS;
          ic  <= '0; ky <= '0; kx <= '0;
          state <= TAP;
        end
        TAP: begin
          if (tap_ok) begin
            input_addr <= in_addr_c;
            input_en   <= 1'b1;
            state      <= RDW;
          end else begin
            ic <= ic_n; ky <= ky_n; kx <= kx_n;
            state <= last_tap ? STORE : TAP;
          end
        end
        RDW: begin
          input_en <= 1'b0;
          state    <= MAC;
        end
        // Read data arrives one cycle after the enable, so it is valid here.
        MAC: begin
          acc <= acc + prod;
          ic <= ic_n; ky <= ky_n; kx <= kx_n;
          state <= last_tap ? STORE : TAP;
        end
        STORE: begin
          output_addr <= out_addr_c;
          output_data <= result;
          output_we   <= 1'b1;
          output_en   <= 1'b1;
          state       <= WRITE;
        end
        WRITE: begin
          output_we <= 1'b0;
          output_en <= 1'b0;
          b <= b_n; oc <= oc_n; oy <= oy_n; ox <= ox_n;
          state <= last_pixel ? DONE_ST : INIT;
        end
        DONE_ST: begin
          done <= 1'b1;
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_transpose2d.md
# conv_transpose2d

Transposed 2-D convolution (deconvolution) engine for the decoder/synthesis path: upsamples a feature map held in an external memory by STRIDE and writes the result to an output memory. It uses the same single-port address/enable memory handshake and start/done control as the encoder-side `conv2d`. Weights and bias are held internally, with all weights at 1 and all bias at 0. It processes one multiply-accumulate per tap, sequentially, and computes each output pixel by gathering its contributing input taps.

## Interface
- BATCH_SIZE, 1, batches processed per start
- IN_CHANNELS, 1, input feature channels
- OUT_CHANNELS, 2, output feature channels
- IN_HEIGHT / IN_WIDTH, 2 / 2, input spatial size
- KERNEL_SIZE, 2, square kernel side
- STRIDE, 2, upsampling stride
- PADDING, 0, implicit output crop per side
- OUTPUT_PADDING, 0, extra rows/cols added at bottom/right
- DATA_WIDTH, 32, signed sample width
- ADDR_WIDTH, 16, memory address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; begins a run when sampled high in IDLE
- done  out  1  run complete; held until start goes low
- valid  out  1  identical to done
- input_addr  out  ADDR_WIDTH  input memory address
- input_data  in  DATA_WIDTH  input memory read data, signed
- input_en  out  1  input memory read enable
- output_addr  out  ADDR_WIDTH  output memory address
- output_data  out  DATA_WIDTH  output write data
- output_we  out  1  output write enable
- output_en  out  1  output enable; always equal to output_we

## Operation
- Output size is derived as follows:
  - OUT_H = (IN_HEIGHT−1)·STRIDE − 2·PADDING + KERNEL_SIZE + OUTPUT_PADDING.
  - OUT_W is derived the same way from IN_WIDTH.
- Memory layouts:
  - Input address = b·IC·IH·IW + ic·IH·IW + iy·IW + ix.
  - Output address = b·OC·OH·OW + oc·OH·OW + oy·OW + ox.
  - Weight index = ic·OC·K·K + oc·K·K + ky·K + kx.
- Loop order, outer to inner: batch, oc, oy, ox. For each pixel, taps run ic outer, then ky, then kx inner.
- Tap validity:
  - Compute ny = oy + PADDING − ky and nx = ox + PADDING − kx as signed values.
  - A tap is valid iff ny ≥ 0, nx ≥ 0, ny mod STRIDE = 0, nx mod STRIDE = 0, iy = ny/STRIDE < IH and ix = nx/STRIDE < IW.
  - Invalid taps contribute 0 and issue no memory read.
- States:
  - IDLE: all outputs low. If start, clear the position counters and go to INIT.
  - INIT: acc ← bias[oc]; clear ic, ky, kx; go to TAP.
  - TAP, valid tap: register input_addr and input_en=1; go to RDW.
  - TAP, invalid tap: advance the tap counters; go to STORE if this was the last tap, else stay in TAP.
  - RDW: input_en ← 0; go to MAC.
  - MAC: acc ← acc + input_data·weight; advance the tap counters; go to STORE if this was the last tap, else TAP.
  - STORE: register output_addr and output_data = acc[DATA_WIDTH−1:0]; set output_we = output_en = 1; go to WRITE.
  - WRITE: output_we = output_en ← 0; advance the pixel position; go to INIT, or to DONE_ST after the last pixel of the last batch.
  - DONE_ST: done = valid ← 1; go to IDLE when start is low.
- Arithmetic:
  - The accumulator is signed DATA_WIDTH+8 bits.
  - Products are full signed products, truncated into the accumulator width.
  - The output is the low DATA_WIDTH bits, with no saturation.
- start is ignored outside IDLE. A start still high in DONE_ST keeps done asserted.

## Timing
- Reset, asynchronous:
  - state = IDLE.
  - done, valid, input_en, output_we, output_en = 0.
  - input_addr, output_addr, output_data = 0.
  - All counters and acc = 0.
  - Reset asserted mid-run aborts the run immediately. No further write is issued after rst deasserts.
- Read handshake:
  - input_en is high for exactly one cycle (RDW).
  - The memory returns data in the following cycle (MAC), and MAC samples it on that cycle's closing edge. This is one-cycle synchronous read latency.
- Write handshake: output_we/output_en are high for exactly one cycle (WRITE), with addr and data stable in that cycle.
- Per-pixel cycle count = 1 (INIT) + 3·(valid taps) + 1·(invalid taps) + 2 (STORE, WRITE).
- Default parameters: 9 cycles per pixel over 32 pixels. Counting from the edge that samples start, DONE_ST is entered at edge 288 and done is high after edge 289.

## Configuration
- CONVT_RELU_EN defined: an accumulator value < 0 is written as 0; non-negative values pass through unchanged. Cycle timing is unchanged.
- CONVT_RELU_EN undefined: the raw truncated accumulator is written.

## Test plan
- Defaults, input [1,2,3,4], start pulse:
  - oc0 addresses 0–15 = 1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4.
  - oc1 addresses 16–31 hold the same values.
  - Exactly 32 write pulses; done after edge 289.
- Defaults, input [−5,7,0,−1], CONVT_RELU_EN undefined: address 0 = 0xFFFFFFFB. With CONVT_RELU_EN defined, address 0 = 0 and address 2 = 7.
- STRIDE=1, K=2, 2×2 input all 1 (3×3 output): centre pixel = 4, corners = 1, edges = 2. Exactly 4 read pulses for the centre pixel.
- Reset asserted during the 5th pixel's RDW: all outputs are 0 in the same cycle, with no write pulse after release. A new start completes a full correct run.
- start held high through DONE_ST: done stays high. When start drops, done falls one cycle later and the block idles with no extra reads or writes.
- Protocol checks throughout all runs:
  - input_en never high on two consecutive cycles.
  - output_we always equals output_en.
  - No read is issued for invalid taps (default run: exactly 32 reads).
